multu_hilo: RTL and testbench
=============================

Name: multu_hilo

Overview:
- Sequential shift-add multiplier that owns the HI/LO register pair.
- Accepts a MULTU function code and two 32-bit operands, then iterates one bit per clock.
- Writes the 64-bit product into HI/LO.
- Its HiOut/LoOut feed the datapath result mux, which returns them on MFHI/MFLO; this block is the writer of the values that mux reads.

Parameters:
- WIDTH, 32, operand width; HiOut/LoOut are WIDTH each, product is 2*WIDTH.
- MULTU_CODE, 6'b011011, function code that starts an unsigned multiply.
- MULT_CODE, 6'b011000, function code that starts a signed multiply (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dataA  input  WIDTH  multiplicand, sampled on the accept edge only.
- dataB  input  WIDTH  multiplier, sampled on the accept edge only.
- Signal  input  6  function code; only MULTU_CODE (and MULT_CODE when enabled) has effect.
- HiOut  output  WIDTH  HI register, upper half of the last completed product.
- LoOut  output  WIDTH  LO register, lower half of the last completed product.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse; HiOut/LoOut were updated on the preceding edge.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately): HiOut=0, LoOut=0, busy=0, done=0, state=IDLE, iteration counter=0, internal product/multiplicand registers=0.
- States:
  - IDLE: wait for a start code.
  - RUN: iterate.
- IDLE -> RUN: at a rising edge with Signal==MULTU_CODE (the accept edge T0):
  - Load multiplicand=dataA.
  - Load product = {WIDTH'b0, dataB}.
  - Clear counter to 0; busy=1 from T0.
- RUN, each edge T1..T32:
  - If product[0]=1, add multiplicand to product[2W-1:W] with a (W+1)-bit carry.
  - Shift {carry, product} right by 1; counter+1.
- RUN -> IDLE at edge T32 (counter reaches WIDTH-1 before that edge):
  - Final shifted product is written directly to HiOut (upper W) and LoOut (lower W).
  - busy=0 and done=1 from T32 for exactly one cycle.
- Latency: result visible 32 edges after the accept edge; busy high for exactly 32 cycles.
- HiOut/LoOut hold their previous values throughout RUN; MFHI/MFLO during busy return the old product. There are no partial updates.
- Signal codes other than start codes never affect state. All codes, including start codes, are ignored while busy=1.
- dataA/dataB changes after T0 have no effect.
- Back-to-back: a start code in the cycle where done=1 (state IDLE) is accepted on the next edge. done then drops and busy rises on that same edge.
- Reset during RUN: operation aborted; HiOut/LoOut cleared to 0, not preserved; no done pulse.
- Zero operands: full 32 cycles, no early exit; result 0.
- No overflow is possible: the 2W-bit product is always exact.

Optional Feature:
- Macro MULT_SIGNED_EN.
- Defined:
  - Signal==MULT_CODE also starts a multiply, treating operands as two's complement.
  - Operand magnitudes are used for the iteration and the operand sign XOR is latched at T0.
  - If the sign is set, the 2W-bit result is negated before the T32 write.
  - Latency is identical, 32 cycles.
- Not defined: MULT_CODE is ignored like any other code; no sign logic is present.

Test Plan:
- Reset, then MULTU with dataA=3, dataB=5 -> busy=1 for 32 cycles, done pulse at T32, HiOut=0x00000000, LoOut=0x0000000F.
- MULTU with 0xFFFFFFFF x 0xFFFFFFFF -> HiOut=0xFFFFFFFE, LoOut=0x00000001. Prior HiOut/LoOut values are unchanged through T31.
- Start 0x00010000 x 0x00010000, assert MULTU with dataA=7, dataB=7 at T10, change dataA/dataB mid-run -> second start ignored, result HiOut=0x00000001, LoOut=0x00000000.
- Issue MULTU 2x2 in the done cycle of a 6x7 multiply -> first result LoOut=42, second accepted immediately, LoOut=4 after 32 more cycles.
- rst_n low at T15 of 0x12345678 x 0x9ABCDEF0 -> HiOut=LoOut=0, busy=0, no done; a following MULTU 1x1 gives LoOut=1.
- With MULT_SIGNED_EN: MULT with dataA=0xFFFFFFFE (-2), dataB=3 -> HiOut=0xFFFFFFFF, LoOut=0xFFFFFFFA. Without the macro, the same stimulus leaves busy=0 and HI/LO unchanged.

Source files
------------

// File: rtl/multu_hilo_if.sv
// Operand/result bundle of the HI/LO multiplier.
// The master drives operands and function code; the slave (multiplier) returns HI/LO and status.
interface multu_hilo_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;
  logic             busy;
  logic             done;

  modport master (
    output dataA, dataB, Signal,
    input  HiOut, LoOut, busy, done
  );

  modport slave (
    input  dataA, dataB, Signal,
    output HiOut, LoOut, busy, done
  );
endinterface

// File: rtl/multu_hilo.sv
// Sequential shift-add multiplier owning the HI/LO register pair.
// One product bit is retired per clock; HI/LO are written only on the final iteration, so reads
// during a run return the previous product.
// Optional macro MULT_SIGNED_EN: MULT_CODE also starts a multiply on two's complement operands.
module multu_hilo #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [5:0]  MULTU_CODE = 6'b011011,
  parameter logic [5:0]  MULT_CODE  = 6'b011000
) (
  input logic        clk,
  input logic        rst_n,
  multu_hilo_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               sign_q, sign_d;

  logic               start;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] result;

  // Start decode and operand conditioning (magnitudes when the signed feature is built in).
  always_comb begin
`ifdef MULT_SIGNED_EN
    start  = (bus.Signal == MULTU_CODE) || (bus.Signal == MULT_CODE);
    op_a   = bus.dataA;
    op_b   = bus.dataB;
    sign_d = sign_q;
    if (bus.Signal == MULT_CODE) begin
      if (bus.dataA[WIDTH-1]) op_a = -bus.dataA;
      if (bus.dataB[WIDTH-1]) op_b = -bus.dataB;
    end
    if (state_q == StIdle && start) begin
      sign_d = (bus.Signal == MULT_CODE) && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
    end
`else
    start  = (bus.Signal == MULTU_CODE);
    op_a   = bus.dataA;
    op_b   = bus.dataB;
    sign_d = 1'b0;
`endif
  end

  // One shift-add iteration; the carry out of the upper-half add becomes the new MSB.
  always_comb begin
    sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    step = {sum, prod_q[WIDTH-1:1]};
`ifdef MULT_SIGNED_EN
    result = sign_q ? -step : step;
`else
    result = step;
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = op_a;
          prod_d  = {{WIDTH{1'b0}}, op_b};
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        prod_d = step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          hi_d    = result[2*WIDTH-1:WIDTH];
          lo_d    = result[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any run and clears HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      sign_q  <= sign_d;
    end
  end

  assign bus.HiOut = hi_q;
  assign bus.LoOut = lo_q;
  assign bus.busy  = (state_q == StRun);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_multu_hilo.sv
// Bench for multu_hilo: a cycle-level behavioural model (product by plain multiplication, fixed
// 32-cycle latency) is compared against HI/LO/busy/done on every falling edge.
module tb_multu_hilo;

  localparam int unsigned W     = 32;
  localparam logic [5:0]  MULTU = 6'b011011;
  localparam logic [5:0]  MULT  = 6'b011000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multu_hilo_if #(.WIDTH(W)) bus ();

  multu_hilo #(
    .WIDTH     (W),
    .MULTU_CODE(MULTU),
    .MULT_CODE (MULT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [63:0] m_prod = '0;
  int          m_rem  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: accept a start code when idle, deliver the exact product 32 edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      m_rem  = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_hi   = m_prod[63:32];
          m_lo   = m_prod[31:0];
        end
      end else if (bus.Signal == MULTU) begin
        m_prod = {32'b0, bus.dataA} * {32'b0, bus.dataB};
        m_busy = 1'b1;
        m_rem  = 32;
      end
`ifdef MULT_SIGNED_EN
      else if (bus.Signal == MULT) begin
        m_prod = 64'(longint'($signed(bus.dataA)) * longint'($signed(bus.dataB)));
        m_busy = 1'b1;
        m_rem  = 32;
      end
`endif
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("hi", 64'(bus.HiOut), 64'(m_hi));
    chk("lo", 64'(bus.LoOut), 64'(m_lo));
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("done", 64'(bus.done), 64'(m_done));
  end

  // Present a code for one accept edge; returns just after that edge (T0).
  task automatic start(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    bus.Signal = code;
    bus.dataA  = a;
    bus.dataB  = b;
    @(posedge clk);
    #1;
    bus.Signal = '0;
  endtask

  // Wait (bounded) for done; returns at the falling edge where done is seen.
  task automatic wait_done(input int budget, output int nbusy);
    bit seen;
    nbusy = 0;
    seen  = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else if (bus.busy) nbusy++;
    end
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
  endtask

  int          nb;
  logic [31:0] ra, rb;
  logic [5:0]  rc;
  bit          is_start;

  initial begin
    bus.Signal = '0;
    bus.dataA  = '0;
    bus.dataB  = '0;
    #12;
    chk("rst_hi", 64'(bus.HiOut), 64'h0);
    chk("rst_lo", 64'(bus.LoOut), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3 x 5
    start(MULTU, 32'd3, 32'd5);
    wait_done(40, nb);
    chk("busy_cycles", 64'(nb), 64'd32);
    chk("t1_hi", 64'(bus.HiOut), 64'h0);
    chk("t1_lo", 64'(bus.LoOut), 64'hF);

    // Max operands
    start(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(40, nb);
    chk("t2_hi", 64'(bus.HiOut), 64'hFFFF_FFFE);
    chk("t2_lo", 64'(bus.LoOut), 64'h0000_0001);

    // Start while busy and operand changes are ignored
    start(MULTU, 32'h0001_0000, 32'h0001_0000);
    repeat (9) @(posedge clk);
    #1;
    bus.Signal = MULTU;
    bus.dataA  = 32'd7;
    bus.dataB  = 32'd7;
    @(posedge clk);
    #1;
    bus.dataA = 32'd5;
    bus.dataB = 32'd9;
    @(posedge clk);
    #1;
    bus.Signal = '0;
    wait_done(40, nb);
    chk("t3_hi", 64'(bus.HiOut), 64'h1);
    chk("t3_lo", 64'(bus.LoOut), 64'h0);

    // Back-to-back start in the done cycle
    start(MULTU, 32'd6, 32'd7);
    wait_done(40, nb);
    chk("t4a_lo", 64'(bus.LoOut), 64'd42);
    bus.Signal = MULTU;
    bus.dataA  = 32'd2;
    bus.dataB  = 32'd2;
    @(posedge clk);
    #1;
    bus.Signal = '0;
    chk("t4_busy_rise", 64'(bus.busy), 64'h1);
    chk("t4_done_drop", 64'(bus.done), 64'h0);
    wait_done(40, nb);
    chk("t4b_lo", 64'(bus.LoOut), 64'd4);

    // Reset mid-run
    start(MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_hi", 64'(bus.HiOut), 64'h0);
    chk("t5_lo", 64'(bus.LoOut), 64'h0);
    chk("t5_busy", 64'(bus.busy), 64'h0);
    chk("t5_done", 64'(bus.done), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start(MULTU, 32'd1, 32'd1);
    wait_done(40, nb);
    chk("t5b_hi", 64'(bus.HiOut), 64'h0);
    chk("t5b_lo", 64'(bus.LoOut), 64'h1);

    // Signed code
    start(MULT, 32'hFFFF_FFFE, 32'd3);
`ifdef MULT_SIGNED_EN
    wait_done(40, nb);
    chk("t6_hi", 64'(bus.HiOut), 64'hFFFF_FFFF);
    chk("t6_lo", 64'(bus.LoOut), 64'hFFFF_FFFA);
`else
    repeat (40) @(negedge clk);
    chk("t6_busy", 64'(bus.busy), 64'h0);
    chk("t6_hi", 64'(bus.HiOut), 64'h0);
    chk("t6_lo", 64'(bus.LoOut), 64'h1);
`endif

    // Randomized operands, codes and mid-run noise
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) ra = '0;
      if ($urandom_range(0, 5) == 0) rb = '0;
      rc = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : MULTU;
      is_start = (rc == MULTU);
`ifdef MULT_SIGNED_EN
      if ($urandom_range(0, 3) == 0) rc = MULT;
      is_start = (rc == MULTU) || (rc == MULT);
`endif
      start(rc, ra, rb);
      if (is_start) begin
        @(posedge clk);
        #1;
        bus.Signal = 6'($urandom);
        bus.dataA  = $urandom;
        bus.dataB  = $urandom;
        @(posedge clk);
        #1;
        bus.Signal = '0;
        wait_done(40, nb);
      end else begin
        repeat (3) @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
